// File: rtl/ws2812_rx.sv
// WS2812/SK6812 800 kHz NRZ receiver: measures DI high widths, decodes GRB pixels MSB
// first, and closes the frame when the line stays low for the latch gap.
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 50000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          DI,
  output logic                          pixel_valid,
  output logic [$clog2(NUM_LEDS)-1:0]   address,
  output logic [7:0]                    green_out,
  output logic [7:0]                    red_out,
  output logic [7:0]                    blue_out,
  output logic                          frame_done,
  output logic [$clog2(NUM_LEDS+1)-1:0] pixel_count,
  output logic                          in_frame,
  output logic                          error,
  output logic                          overflow
);

  localparam int CYCLE_COUNT  = SYSTEM_CLOCK / 800_000;
  localparam int THRESH       = 3 * CYCLE_COUNT / 8;
  localparam int MIN_HIGH     = CYCLE_COUNT / 8;
  localparam int MAX_HIGH     = 2 * CYCLE_COUNT;
  localparam int RESET_DETECT = SYSTEM_CLOCK / 25_000;
  localparam int AW = $clog2(NUM_LEDS);
  localparam int CW = $clog2(NUM_LEDS + 1);
  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_DETECT + 1);

  localparam logic [HW-1:0] THRESH_C = HW'(THRESH);
  localparam logic [HW-1:0] MIN_C    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_C    = HW'(MAX_HIGH);
  localparam logic [LW-1:0] RD_C     = LW'(RESET_DETECT);
  localparam logic [LW-1:0] RD_M1_C  = LW'(RESET_DETECT - 1);
  localparam logic [CW-1:0] NUM_C    = CW'(NUM_LEDS);

  // SYNC: waiting for a full latch gap | IDLE: between frames
  // HIGH: measuring a high pulse       | LOW: measuring the gap after a bit
  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            di_d_q;
  logic [HW-1:0]   high_cnt_q, high_cnt_d;
  logic [LW-1:0]   low_cnt_q, low_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   address_q, address_d;
  logic [7:0]      green_q, green_d, red_q, red_d, blue_q, blue_d;
  logic            pv_q, pv_d, fd_q, fd_d, err_q, err_d;
  logic            in_frame_q, in_frame_d, ovf_q, ovf_d;

  logic            di_s, rise, fall, bit_val;
  logic [23:0]     full_pixel;

  assign di_s       = sync_q[1];
  assign rise       = di_s & ~di_d_q;
  assign fall       = ~di_s & di_d_q;
  assign bit_val    = (high_cnt_q >= THRESH_C);
  assign full_pixel = {shift_q[22:0], bit_val};

  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    address_d  = address_q;
    green_d    = green_q;
    red_d      = red_q;
    blue_d     = blue_q;
    pv_d       = 1'b0;
    fd_d       = 1'b0;
    err_d      = 1'b0;
    in_frame_d = in_frame_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_SYNC: begin
        if (di_s) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == RD_M1_C) begin
          low_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          low_cnt_d = low_cnt_q + LW'(1);
        end
      end
      S_IDLE: begin
        if (rise) begin
          state_d    = S_HIGH;
          high_cnt_d = HW'(1);
          bit_cnt_d  = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          in_frame_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (fall) begin
          if (high_cnt_q < MIN_C) begin
            err_d      = 1'b1;
            in_frame_d = 1'b0;
            low_cnt_d  = '0;
            state_d    = S_SYNC;
          end else begin
            shift_d   = full_pixel;
            low_cnt_d = LW'(1);
            state_d   = S_LOW;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              green_d   = full_pixel[23:16];
              red_d     = full_pixel[15:8];
              blue_d    = full_pixel[7:0];
              // Pixels beyond NUM_LEDS are still decoded but only flagged.
              if (cnt_q < NUM_C) begin
                pv_d      = 1'b1;
                address_d = cnt_q[AW-1:0];
                cnt_d     = cnt_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else if (high_cnt_q == MAX_C) begin
          err_d      = 1'b1;
          in_frame_d = 1'b0;
          low_cnt_d  = '0;
          state_d    = S_SYNC;
        end else begin
          high_cnt_d = high_cnt_q + HW'(1);
        end
      end
      S_LOW: begin
        if (rise) begin
          high_cnt_d = HW'(1);
          state_d    = S_HIGH;
        end else if (low_cnt_q == RD_M1_C) begin
          fd_d       = 1'b1;
          err_d      = (bit_cnt_q != 5'd0);
          in_frame_d = 1'b0;
          state_d    = S_IDLE;
        end else if (low_cnt_q < RD_C) begin
          low_cnt_d = low_cnt_q + LW'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SYNC;
      sync_q     <= '0;
      di_d_q     <= 1'b0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      address_q  <= '0;
      green_q    <= '0;
      red_q      <= '0;
      blue_q     <= '0;
      pv_q       <= 1'b0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      in_frame_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], DI};
      di_d_q     <= sync_q[1];
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      address_q  <= address_d;
      green_q    <= green_d;
      red_q      <= red_d;
      blue_q     <= blue_d;
      pv_q       <= pv_d;
      fd_q       <= fd_d;
      err_q      <= err_d;
      in_frame_q <= in_frame_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pixel_valid = pv_q;
  assign address     = address_q;
  assign green_out   = green_q;
  assign red_out     = red_q;
  assign blue_out    = blue_q;
  assign frame_done  = fd_q;
  assign pixel_count = cnt_q;
  assign in_frame    = in_frame_q;
  assign error       = err_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives pulse trains and compares strobes against a
// pulse-level decoding model of the WS2812 protocol.
module tb_ws2812_rx;
  localparam int RD   = 2000;
  localparam int MINH = 7;
  localparam int MAXH = 124;
  localparam int THR  = 23;

  logic       clk = 1'b0;
  logic       reset, DI;
  logic       pixel_valid, frame_done, in_frame, error, overflow;
  logic [2:0] address;
  logic [3:0] pixel_count;
  logic [7:0] green_out, red_out, blue_out;

  ws2812_rx #(.NUM_LEDS(8), .SYSTEM_CLOCK(50000000)) dut (
    .clk(clk), .reset(reset), .DI(DI), .pixel_valid(pixel_valid), .address(address),
    .green_out(green_out), .red_out(red_out), .blue_out(blue_out), .frame_done(frame_done),
    .pixel_count(pixel_count), .in_frame(in_frame), .error(error), .overflow(overflow));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  logic [63:0] obs_pix[$], exp_pix[$];
  logic [15:0] obs_fd[$], exp_fd[$];
  int obs_err = 0, exp_err = 0, bad_strobe = 0;

  bit m_ready, m_open;
  int m_bits, m_idx;
  logic [23:0] m_acc = '0;

  always @(negedge clk) begin
    if (pixel_valid) obs_pix.push_back({32'(cyc), 5'd0, address, green_out, red_out, blue_out});
    if (frame_done) obs_fd.push_back({7'd0, error, 4'd0, pixel_count});
    else if (error) obs_err++;
    if (pixel_valid && (frame_done || error)) bad_strobe++;
  end

  // Expected behaviour per pulse: width classifies the bit or an error; a low of
  // at least RD cycles closes the frame; 24 bits make a pixel.
  task automatic model(input int hi, input int lo, input int fc);
    logic b;
    if (!m_ready) begin m_ready = (lo > RD); return; end
    if (!m_open) begin m_open = 1; m_idx = 0; m_bits = 0; end
    if (hi < MINH || hi > MAXH) begin
      exp_err++; m_open = 0; m_ready = (lo > RD); return;
    end
    b = (hi >= THR);
    m_acc = {m_acc[22:0], b};
    m_bits++;
    if (m_bits == 24) begin
      m_bits = 0;
      if (m_idx < 8) begin
        exp_pix.push_back({32'(fc + 3), 8'(m_idx), m_acc});
        m_idx++;
      end
    end
    if (lo >= RD) begin
      exp_fd.push_back({7'd0, m_bits != 0, 4'd0, 4'(m_idx)});
      m_open = 0;
    end
  endtask

  task automatic hold(input logic v, input int n);
    DI = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    int fc;
    hold(1'b1, hi);
    fc = cyc;
    hold(1'b0, lo);
    model(hi, lo, fc);
  endtask

  task automatic send_px(input logic [23:0] grb, input int nbits, input int h0a, input int h0b,
                         input int h1a, input int h1b, input int last_lo);
    int hi, lo;
    for (int i = nbits - 1; i >= 0; i--) begin
      hi = grb[i] ? int'($urandom_range(h1b, h1a)) : int'($urandom_range(h0b, h0a));
      lo = (hi < 60) ? 62 - hi : int'($urandom_range(30, 2));
      if (i == 0 && last_lo > 0) lo = last_lo;
      pulse(hi, lo);
    end
  endtask

  task automatic clear_q();
    obs_pix.delete(); exp_pix.delete(); obs_fd.delete(); exp_fd.delete();
    obs_err = 0; exp_err = 0;
  endtask

  task automatic test_reset();
    DI = 1'b0; reset = 1'b1;
    m_ready = 0; m_open = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if ({pixel_valid, frame_done, error, in_frame, overflow, address, pixel_count,
         green_out, red_out, blue_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got pv=%b fd=%b err=%b inf=%b ovf=%b addr=%0d cnt=%0d g=%h r=%h b=%h want all 0",
        pixel_valid, frame_done, error, in_frame, overflow, address, pixel_count, green_out, red_out, blue_out);
    end
    hold(1'b0, 2100);
    m_ready = 1;
  endtask

  task automatic test_basic();
    send_px(24'h123456, 24, 15, 15, 31, 31, 0);
    n_checks++;
    if (in_frame !== 1'b1) begin n_fail++; $display("FAIL basic_in_frame got=%b want=1", in_frame); end
    send_px(24'hFF00A5, 24, 15, 15, 31, 31, 0);
    send_px(24'h000001, 24, 15, 15, 31, 31, 6200);
    n_checks++;
    if (in_frame !== 1'b0) begin n_fail++; $display("FAIL basic_in_frame_end got=%b want=0", in_frame); end
    n_checks++;
    if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL basic_pix_n got=%0d want=%0d", obs_pix.size(), exp_pix.size()); end
    else foreach (exp_pix[i]) begin
      n_checks++;
      if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL basic_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]); end
    end
    n_checks++;
    if (obs_fd.size() != exp_fd.size()) begin n_fail++; $display("FAIL basic_fd_n got=%0d want=%0d", obs_fd.size(), exp_fd.size()); end
    else foreach (exp_fd[i]) begin
      n_checks++;
      if (obs_fd[i] !== exp_fd[i]) begin n_fail++; $display("FAIL basic_fd[%0d] got=%h want=%h", i, obs_fd[i], exp_fd[i]); end
    end
    n_checks++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL basic_err got=%0d want=%0d", obs_err, exp_err); end
    clear_q();
  endtask

  task automatic test_threshold();
    send_px($urandom(), 24, 22, 22, 23, 23, 1999);
    send_px($urandom(), 24, 7, 22, 23, 124, 2000);
    send_px($urandom(), 24, 7, 22, 23, 124, 2100);
    n_checks++;
    if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL thresh_pix_n got=%0d want=%0d", obs_pix.size(), exp_pix.size()); end
    else foreach (exp_pix[i]) begin
      n_checks++;
      if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL thresh_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]); end
    end
    n_checks++;
    if (obs_fd.size() != exp_fd.size()) begin n_fail++; $display("FAIL thresh_fd_n got=%0d want=%0d", obs_fd.size(), exp_fd.size()); end
    else foreach (exp_fd[i]) begin
      n_checks++;
      if (obs_fd[i] !== exp_fd[i]) begin n_fail++; $display("FAIL thresh_fd[%0d] got=%h want=%h", i, obs_fd[i], exp_fd[i]); end
    end
    n_checks++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL thresh_err got=%0d want=%0d", obs_err, exp_err); end
    clear_q();
  endtask

  task automatic test_overflow();
    for (int p = 0; p < 10; p++) send_px($urandom(), 24, 15, 15, 31, 31, (p == 9) ? 2100 : 0);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", overflow); end
    pulse(31, 31);
    n_checks++;
    if ({overflow, in_frame} !== 2'b01) begin n_fail++; $display("FAIL ovf_clear got ovf=%b inf=%b want ovf=0 inf=1", overflow, in_frame); end
    send_px($urandom(), 23, 15, 15, 31, 31, 2100);
    n_checks++;
    if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL ovf_pix_n got=%0d want=%0d", obs_pix.size(), exp_pix.size()); end
    else foreach (exp_pix[i]) begin
      n_checks++;
      if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL ovf_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]); end
    end
    n_checks++;
    if (obs_fd.size() != exp_fd.size()) begin n_fail++; $display("FAIL ovf_fd_n got=%0d want=%0d", obs_fd.size(), exp_fd.size()); end
    else foreach (exp_fd[i]) begin
      n_checks++;
      if (obs_fd[i] !== exp_fd[i]) begin n_fail++; $display("FAIL ovf_fd[%0d] got=%h want=%h", i, obs_fd[i], exp_fd[i]); end
    end
    n_checks++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL ovf_err got=%0d want=%0d", obs_err, exp_err); end
    clear_q();
  endtask

  task automatic test_glitch();
    send_px($urandom(), 24, 15, 15, 31, 31, 0);
    send_px($urandom(), 5, 15, 15, 31, 31, 0);
    pulse(5, 40);
    n_checks++;
    if (in_frame !== 1'b0) begin n_fail++; $display("FAIL glitch_in_frame got=%b want=0", in_frame); end
    for (int k = 0; k < 10; k++) pulse(31, 31);
    pulse(31, 2500);
    send_px($urandom(), 24, 15, 15, 31, 31, 0);
    send_px($urandom(), 24, 15, 15, 31, 31, 2100);
    n_checks++;
    if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL glitch_pix_n got=%0d want=%0d", obs_pix.size(), exp_pix.size()); end
    else foreach (exp_pix[i]) begin
      n_checks++;
      if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL glitch_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]); end
    end
    n_checks++;
    if (obs_fd.size() != exp_fd.size()) begin n_fail++; $display("FAIL glitch_fd_n got=%0d want=%0d", obs_fd.size(), exp_fd.size()); end
    else foreach (exp_fd[i]) begin
      n_checks++;
      if (obs_fd[i] !== exp_fd[i]) begin n_fail++; $display("FAIL glitch_fd[%0d] got=%h want=%h", i, obs_fd[i], exp_fd[i]); end
    end
    n_checks++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL glitch_err got=%0d want=%0d", obs_err, exp_err); end
    clear_q();
  endtask

  task automatic test_stuck();
    pulse(130, 2500);
    n_checks++;
    if (in_frame !== 1'b0) begin n_fail++; $display("FAIL stuck_in_frame got=%b want=0", in_frame); end
    send_px($urandom(), 12, 15, 15, 31, 31, 6200);
    n_checks++;
    if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL stuck_pix_n got=%0d want=%0d", obs_pix.size(), exp_pix.size()); end
    n_checks++;
    if (obs_fd.size() != exp_fd.size()) begin n_fail++; $display("FAIL stuck_fd_n got=%0d want=%0d", obs_fd.size(), exp_fd.size()); end
    else foreach (exp_fd[i]) begin
      n_checks++;
      if (obs_fd[i] !== exp_fd[i]) begin n_fail++; $display("FAIL stuck_fd[%0d] got=%h want=%h", i, obs_fd[i], exp_fd[i]); end
    end
    n_checks++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL stuck_err got=%0d want=%0d", obs_err, exp_err); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    send_px($urandom(), 10, 15, 15, 31, 31, 0);
    hold(1'b1, 10);
    reset = 1'b1;
    hold(1'b1, 1);
    reset = 1'b0;
    m_ready = 0; m_open = 0;
    n_checks++;
    if ({pixel_valid, frame_done, error, in_frame, overflow, address, pixel_count,
         green_out, red_out, blue_out} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got inf=%b cnt=%0d g=%h r=%h b=%h want all 0",
        in_frame, pixel_count, green_out, red_out, blue_out);
    end
    for (int k = 0; k < 10; k++) pulse(31, 31);
    pulse(31, 2500);
    send_px($urandom(), 24, 15, 15, 31, 31, 2100);
    n_checks++;
    if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL midreset_pix_n got=%0d want=%0d", obs_pix.size(), exp_pix.size()); end
    else foreach (exp_pix[i]) begin
      n_checks++;
      if (obs_pix[i] !== exp_pix[i]) begin n_fail++; $display("FAIL midreset_pix[%0d] got=%h want=%h", i, obs_pix[i], exp_pix[i]); end
    end
    n_checks++;
    if (obs_fd.size() != exp_fd.size()) begin n_fail++; $display("FAIL midreset_fd_n got=%0d want=%0d", obs_fd.size(), exp_fd.size()); end
    else foreach (exp_fd[i]) begin
      n_checks++;
      if (obs_fd[i] !== exp_fd[i]) begin n_fail++; $display("FAIL midreset_fd[%0d] got=%h want=%h", i, obs_fd[i], exp_fd[i]); end
    end
    n_checks++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL midreset_err got=%0d want=%0d", obs_err, exp_err); end
    clear_q();
  endtask

  task automatic test_strobe_exclusive();
    n_checks++;
    if (bad_strobe != 0) begin n_fail++; $display("FAIL strobe_overlap got=%0d want=0", bad_strobe); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_overflow();
    test_glitch();
    test_stuck();
    test_reset_mid();
    test_strobe_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
